// File: rtl/char_msg_pkg.sv
// ---------------------------------------------------------------------------
// char_msg_pkg
// Shared definitions for the character-message overlay controller:
//   - state_t     : controller states (IDLE, TYPE, HOLD)
//   - MSG_*       : character ROM page numbers for the known messages
// ---------------------------------------------------------------------------
package char_msg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TYPE = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] MSG_GRA2   = 2'd0;
  localparam logic [1:0] MSG_KONIEC = 2'd1;
  localparam logic [1:0] MSG_START  = 2'd2;

endpackage

// File: rtl/frame_tick_div.sv
// ---------------------------------------------------------------------------
// frame_tick_div
// Counts tick_in pulses and emits pulse_out on every DIV-th one (or every
// ALT_DIV-th one while alt_sel is high). The counter restarts from zero
// whenever clr is high.
// Ports:
//   clk       in  system clock, rising edge
//   rst       in  asynchronous active-low reset
//   clr       in  synchronous counter clear
//   alt_sel   in  select ALT_DIV instead of DIV as the division ratio
//   tick_in   in  one-cycle input pulse to be counted
//   pulse_out out combinational pulse, coincident with the dividing tick
// ---------------------------------------------------------------------------
module frame_tick_div #(
  parameter int DIV     = 2,
  parameter int ALT_DIV = DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic alt_sel,
  input  logic tick_in,
  output logic pulse_out
);

  localparam int MAX_DIV = (DIV > ALT_DIV) ? DIV : ALT_DIV;
  localparam int CW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  localparam logic [CW-1:0] LIM_MAIN = CW'(DIV - 1);
  localparam logic [CW-1:0] LIM_ALT  = CW'(ALT_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;

  assign lim = alt_sel ? LIM_ALT : LIM_MAIN;

  // The pulse is deliberately not gated by clr: the owner uses the pulse to
  // decide whether to clear, and gating would close a combinational loop.
  assign pulse_out = tick_in & (cnt == lim);

  // Count ticks 0..lim and wrap; clr restarts the count so that a tick in
  // the clearing cycle is discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick_in) begin
      cnt <= (cnt == lim) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/char_msg_ctrl.sv
// ---------------------------------------------------------------------------
// char_msg_ctrl
// Types out an on-screen message one character at a time, holds the full
// message with a blinking overlay, then clears it and pulses done.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   frame_tick  in   one pulse per video frame
//   show_req    in   request to start a message (accepted only in IDLE)
//   msg_sel     in   page to display, latched on acceptance
//   cancel      in   abort the message in TYPE or HOLD
//   busy        out  high outside IDLE
//   overlay_en  out  overlay visible
//   page        out  latched character ROM page
//   reveal_cnt  out  number of leading characters drawn
//   blink_on    out  overlay blink phase
//   done        out  one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module char_msg_ctrl
  import char_msg_pkg::*;
#(
  parameter int MSG_LEN         = 32,
  parameter int FRAMES_PER_CHAR = 2,
  parameter int HOLD_FRAMES     = 180,
  parameter int BLINK_HALF      = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       show_req,
  input  logic [1:0] msg_sel,
  input  logic       cancel,
  output logic       busy,
  output logic       overlay_en,
  output logic [1:0] page,
  output logic [8:0] reveal_cnt,
  output logic       blink_on,
  output logic       done
);

  localparam logic [8:0] MSG_LEN_V = 9'(MSG_LEN);

  state_t     state, state_n;
  logic       busy_n, overlay_n, blink_n, done_n;
  logic [1:0] page_n;
  logic [8:0] reveal_n;
  logic       pace_clr, hold_clr;
  logic       pace_pulse, hold_pulse;

  // One divider paces characters in TYPE and blink half-periods in HOLD;
  // the mode switch always coincides with a clear.
  frame_tick_div #(
    .DIV     (FRAMES_PER_CHAR),
    .ALT_DIV (BLINK_HALF)
  ) u_pace_div (
    .clk       (clk),
    .rst       (rst),
    .clr       (pace_clr),
    .alt_sel   (state == HOLD),
    .tick_in   (frame_tick),
    .pulse_out (pace_pulse)
  );

  frame_tick_div #(
    .DIV     (HOLD_FRAMES),
    .ALT_DIV (HOLD_FRAMES)
  ) u_hold_div (
    .clk       (clk),
    .rst       (rst),
    .clr       (hold_clr),
    .alt_sel   (1'b0),
    .tick_in   (frame_tick),
    .pulse_out (hold_pulse)
  );

  // Next-state and next-output logic. The dividers are held cleared in IDLE
  // and cleared on every state change, so a tick in the entry cycle never
  // counts toward the new state.
  always_comb begin
    state_n   = state;
    busy_n    = busy;
    overlay_n = overlay_en;
    page_n    = page;
    reveal_n  = reveal_cnt;
    blink_n   = blink_on;
    done_n    = 1'b0;
    pace_clr  = 1'b0;
    hold_clr  = (state != HOLD);

    case (state)
      IDLE: begin
        pace_clr = 1'b1;
        if (show_req) begin
          state_n   = TYPE;
          page_n    = msg_sel;
          reveal_n  = '0;
          overlay_n = 1'b1;
          blink_n   = 1'b1;
          busy_n    = 1'b1;
        end
      end

      TYPE: begin
        if (cancel) begin
          state_n   = IDLE;
          busy_n    = 1'b0;
          overlay_n = 1'b0;
          blink_n   = 1'b0;
          reveal_n  = '0;
          pace_clr  = 1'b1;
        end else if (pace_pulse && (reveal_cnt < MSG_LEN_V)) begin
          reveal_n = reveal_cnt + 9'd1;
          if (reveal_n == MSG_LEN_V) begin
            state_n  = HOLD;
            pace_clr = 1'b1;
          end
        end
      end

      HOLD: begin
        // Completion takes priority over a blink toggle on the same tick.
        if (cancel || hold_pulse) begin
          state_n   = IDLE;
          busy_n    = 1'b0;
          overlay_n = 1'b0;
          blink_n   = 1'b0;
          reveal_n  = '0;
          pace_clr  = 1'b1;
          done_n    = ~cancel;
        end else if (pace_pulse) begin
          blink_n = ~blink_on;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      overlay_en <= 1'b0;
      page       <= 2'd0;
      reveal_cnt <= '0;
      blink_on   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      busy       <= busy_n;
      overlay_en <= overlay_n;
      page       <= page_n;
      reveal_cnt <= reveal_n;
      blink_on   <= blink_n;
      done       <= done_n;
    end
  end

endmodule

// File: doc/char_msg_ctrl.md
CHAR_MSG_CTRL -- requirements
Module: char_msg_ctrl

Interface
REQ-001 SHALL have parameter MSG_LEN, default 32: characters revealed per message, legal range 1..256.
REQ-002 SHALL have parameter FRAMES_PER_CHAR, default 2: frame ticks per revealed character, legal range 1..255.
REQ-003 SHALL have parameter HOLD_FRAMES, default 180: frame ticks the full message is held, legal range 1..65535.
REQ-004 SHALL have parameter BLINK_HALF, default 30: frame ticks per blink half-period during hold, legal range 1..255.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 frame_tick  in  1  one-cycle pulse per video frame, synchronous to clk.
REQ-008 show_req  in  1  one-cycle request to display a message.
REQ-009 msg_sel  in  2  message page, sampled only when show_req is accepted.
REQ-010 cancel  in  1  abort the current message.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 overlay_en  out  1  character overlay visible.
REQ-013 page  out  2  latched msg_sel; selects the char ROM page.
REQ-014 reveal_cnt  out  9  number of leading characters drawn, 0..MSG_LEN.
REQ-015 blink_on  out  1  overlay phase; the drawer draws only when high.
REQ-016 done  out  1  one-cycle pulse on normal completion.

Function
REQ-017 SHALL implement FSM states IDLE, TYPE, HOLD; all outputs SHALL be registered.
REQ-018 IDLE, show_req=1 -> TYPE next cycle: page<=msg_sel, reveal_cnt<=0, overlay_en<=1, blink_on<=1, busy<=1; frame divider cleared.
REQ-019 TYPE: reveal_cnt SHALL increment by 1 on every FRAMES_PER_CHAR-th frame_tick counted since entry; it SHALL saturate at MSG_LEN.
REQ-020 TYPE -> HOLD in the same cycle reveal_cnt becomes MSG_LEN; hold and blink counters cleared; blink_on stays 1.
REQ-021 HOLD: blink_on SHALL toggle every BLINK_HALF frame_ticks; the hold counter SHALL count frame_ticks.
REQ-022 HOLD, HOLD_FRAMES-th frame_tick -> IDLE; done=1 for exactly one cycle; overlay_en, blink_on, busy <=0; reveal_cnt <=0; page is retained.
REQ-023 cancel=1 in TYPE or HOLD -> IDLE next cycle with the same outputs as REQ-022, except done stays 0.
REQ-024 cancel and show_req together in TYPE or HOLD: cancel wins and the request is dropped. In IDLE, cancel is ignored and show_req is accepted.
REQ-025 show_req in TYPE or HOLD without cancel SHALL be ignored; page SHALL NOT change.
REQ-026 frame_tick coincident with the state-entry cycle SHALL NOT be counted; counting starts the cycle after entry.
REQ-027 Counters SHALL be sized from parameters ($clog2) and SHALL never wrap within one message.

Reset
REQ-028 rst low SHALL asynchronously force state=IDLE, busy=0, overlay_en=0, page=0, reveal_cnt=0, blink_on=0, done=0, and all counters=0.
REQ-029 Reset mid-TYPE or mid-HOLD SHALL NOT produce a done pulse; the first show_req after release SHALL be accepted.

Structure
REQ-030 Package char_msg_pkg SHALL hold the state enum (IDLE, TYPE, HOLD) and page constants MSG_GRA2=2'd0, MSG_KONIEC=2'd1, MSG_START=2'd2.
REQ-031 Sub-module frame_tick_div SHALL exist: parameterised divider with ports clk, rst, clr, tick_in, pulse_out. It is instantiated twice: once for char/blink pacing and once for the hold count.

Verification (MSG_LEN=4, FRAMES_PER_CHAR=2, HOLD_FRAMES=6, BLINK_HALF=2)
REQ-032 show_req, msg_sel=1 in IDLE -> next cycle busy=1, overlay_en=1, page=1, reveal_cnt=0; reveal_cnt steps 1,2,3,4 on frame_ticks 2,4,6,8; state=HOLD after tick 8.
REQ-033 In HOLD, 6 frame_ticks -> blink_on 1,0,0,1,1 pattern toggling after ticks 2 and 4; after tick 6, done=1 for one cycle, then busy=0, overlay_en=0, reveal_cnt=0.
REQ-034 cancel after reveal_cnt=2 -> IDLE next cycle, done never asserted, page still 1.
REQ-035 show_req and cancel in the same cycle during HOLD -> IDLE, request dropped; show_req and cancel in the same cycle in IDLE -> TYPE.
REQ-036 rst low during TYPE with reveal_cnt=3 -> all outputs 0 immediately (asynchronous); after release, show_req with msg_sel=2 -> page=2, reveal_cnt=0.
REQ-037 show_req with msg_sel=3 during TYPE -> ignored, page unchanged, reveal sequence uninterrupted.
